// File: rtl/gate_sweep_if.sv
// gate_sweep_if: start/z in, gate stimulus and sweep results out, for gate_sweep_ctrl.
interface gate_sweep_if;
    logic       start;
    logic       z;
    logic       x;
    logic       y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_mask;
    logic [1:0] vec_idx;
    modport slave (
        input  start, z,
        output x, y, busy, done, pass, err_mask, vec_idx
    );
    modport master (
        output start, z,
        input  x, y, busy, done, pass, err_mask, vec_idx
    );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: drives a 2-input gate through all four input vectors, lets z settle,
// and checks it against the EXPECT truth table, reporting a per-vector error mask and a pass flag.
module gate_sweep_ctrl #(
    parameter int         SETTLE = 2,
    parameter logic [3:0] EXPECT = 4'b0110
) (
    input logic        clk,
    input logic        rst_n,
    gate_sweep_if.slave bus
);
    localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, FIN} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       miss;
    logic [3:0] miss_vec;
    logic [1:0] next_idx;

    // case inequality so an undriven or X gate output is reported, not masked
    always_comb begin
        miss     = bus.z !== EXPECT[bus.vec_idx];
        miss_vec = {3'b000, miss} << bus.vec_idx;
        next_idx = bus.vec_idx + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            bus.x        <= 1'b0;
            bus.y        <= 1'b0;
            bus.vec_idx  <= 2'd0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.pass     <= 1'b0;
            bus.err_mask <= 4'd0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    state        <= DRIVE;
                    cnt          <= RELOAD;
                    bus.x        <= 1'b0;
                    bus.y        <= 1'b0;
                    bus.vec_idx  <= 2'd0;
                    bus.busy     <= 1'b1;
                    bus.pass     <= 1'b0;
                    bus.err_mask <= 4'd0;
                end
                DRIVE: begin
                    if (cnt == 4'd0) state <= CHECK;
                    else cnt <= cnt - 4'd1;
                end
                CHECK: begin
                    bus.err_mask <= bus.err_mask | miss_vec;
                    if (bus.vec_idx == 2'd3) begin
                        state    <= FIN;
                        bus.done <= 1'b1;
                        bus.pass <= (bus.err_mask | miss_vec) == 4'd0;
                        bus.x    <= 1'b0;
                        bus.y    <= 1'b0;
                    end else begin
                        state       <= DRIVE;
                        cnt         <= RELOAD;
                        bus.vec_idx <= next_idx;
                        bus.x       <= next_idx[1];
                        bus.y       <= next_idx[0];
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl: two sweepers (default and SETTLE=1/AND) checked every cycle against a
// timeline model of the sweep, plus literal checks of latency, masks and control corner cases.
module tb_gate_sweep_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    int   mode_a = 0, mode_b = 2;
    logic [3:0] tab_a = 4'd0, tab_b = 4'd0;
    int   checks = 0, errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    gate_sweep_if ia ();
    gate_sweep_if ib ();

    function automatic logic zf(int m, logic [3:0] tab, logic x, logic y);
        return m == 0 ? x ^ y : m == 1 ? 1'b0 : m == 2 ? x & y : tab[{x, y}];
    endfunction

    assign ia.start = start;
    assign ib.start = start;
    assign ia.z = zf(mode_a, tab_a, ia.x, ia.y);
    assign ib.z = zf(mode_b, tab_b, ib.x, ib.y);

    gate_sweep_ctrl dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
    gate_sweep_ctrl #(.SETTLE(1), .EXPECT(4'b1000)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

    // Model: t counts edges since acceptance; vector k is judged at t=(k+1)*(SETTLE+1).
    typedef struct {
        bit         act;
        int         t;
        logic       x, y, busy, done, pass;
        logic [1:0] vec;
        logic [3:0] mask;
    } ms_t;

    function automatic ms_t step(ms_t s, logic rn, logic st, logic z, int settle, logic [3:0] exp);
        int l;
        int k;
        l = settle + 1;
        if (!rn) begin
            s = '{default: 0};
            return s;
        end
        if (!s.act) begin
            if (st) begin
                s.act = 1; s.t = 0; s.mask = 0; s.pass = 0; s.vec = 0;
                s.x = 0; s.y = 0; s.busy = 1; s.done = 0;
            end
            return s;
        end
        s.t++;
        if (s.t % l == 0 && s.t <= 4 * l) begin
            k = s.t / l - 1;
            if (z !== exp[k]) s.mask[k] = 1'b1;
            if (k < 3) begin
                s.vec = 2'(k + 1);
                {s.x, s.y} = s.vec;
            end else begin
                s.done = 1; s.pass = s.mask == 4'd0; s.x = 0; s.y = 0;
            end
        end else if (s.t == 4 * l + 1) begin
            s.act = 0; s.busy = 0; s.done = 0;
        end
        return s;
    endfunction

    ms_t ma = '{default: 0};
    ms_t mb = '{default: 0};

    always @(posedge clk) begin
        ma = step(ma, rst_n, start, ia.z, 2, 4'b0110);
        mb = step(mb, rst_n, start, ib.z, 1, 4'b1000);
        cyc++;
    end

    function automatic logic [10:0] pk(logic b, logic d, logic p, logic x, logic y, logic [1:0] v, logic [3:0] m);
        return {b, d, p, x, y, v, m};
    endfunction

    always @(negedge clk) if (cyc > 0) begin
        checks += 2;
        if (pk(ia.busy, ia.done, ia.pass, ia.x, ia.y, ia.vec_idx, ia.err_mask) !== pk(ma.busy, ma.done, ma.pass, ma.x, ma.y, ma.vec, ma.mask)) begin
            errors++;
            $display("FAIL dut_a cyc %0d {busy,done,pass,x,y,vec,mask} got %b want %b", cyc,
                pk(ia.busy, ia.done, ia.pass, ia.x, ia.y, ia.vec_idx, ia.err_mask), pk(ma.busy, ma.done, ma.pass, ma.x, ma.y, ma.vec, ma.mask));
        end
        if (pk(ib.busy, ib.done, ib.pass, ib.x, ib.y, ib.vec_idx, ib.err_mask) !== pk(mb.busy, mb.done, mb.pass, mb.x, mb.y, mb.vec, mb.mask)) begin
            errors++;
            $display("FAIL dut_b cyc %0d {busy,done,pass,x,y,vec,mask} got %b want %b", cyc,
                pk(ib.busy, ib.done, ib.pass, ib.x, ib.y, ib.vec_idx, ib.err_mask), pk(mb.busy, mb.done, mb.pass, mb.x, mb.y, mb.vec, mb.mask));
        end
    end

    // Event monitor for the literal latency/gap checks, observed on the DUT pins only.
    int   acc_a = 0, dcyc_a = 0, lat_a = 0, nd_a = 0, gap_a = 0;
    int   acc_b = 0, lat_b = 0, nd_b = 0;
    logic pb_a = 1'b0, pd_a = 1'b0, pb_b = 1'b0, pd_b = 1'b0;

    always @(negedge clk) begin
        if (ia.busy === 1'b1 && !pb_a) begin acc_a = cyc; gap_a = cyc - dcyc_a; end
        if (ia.done === 1'b1 && !pd_a) begin dcyc_a = cyc; lat_a = cyc - acc_a + 1; nd_a++; end
        if (ib.busy === 1'b1 && !pb_b) acc_b = cyc;
        if (ib.done === 1'b1 && !pd_b) begin lat_b = cyc - acc_b + 1; nd_b++; end
        pb_a = ia.busy === 1'b1; pd_a = ia.done === 1'b1;
        pb_b = ib.busy === 1'b1; pd_b = ib.done === 1'b1;
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic sweep(int wait_n);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (wait_n) @(negedge clk);
    endtask

    int nd0;

    initial begin
        repeat (2) @(negedge clk);
        chk("reset busy", int'(ia.busy), 0);
        chk("reset xy", int'({ia.x, ia.y}), 0);
        chk("reset mask", int'(ia.err_mask), 0);
        rst_n = 1'b1;
        // xor on default sweeper, AND on the SETTLE=1/EXPECT=1000 sweeper
        mode_a = 0; mode_b = 2;
        sweep(20);
        chk("xor latency", lat_a, 13);
        chk("xor pass", int'(ia.pass), 1);
        chk("xor mask", int'(ia.err_mask), 0);
        chk("xor done count", nd_a, 1);
        chk("settle1 latency", lat_b, 9);
        chk("settle1 pass", int'(ib.pass), 1);
        chk("settle1 mask", int'(ib.err_mask), 0);
        mode_a = 1;
        sweep(20);
        chk("zero mask", int'(ia.err_mask), 4'b0110);
        chk("zero pass", int'(ia.pass), 0);
        mode_a = 2;
        sweep(20);
        chk("and mask", int'(ia.err_mask), 4'b1110);
        chk("and pass", int'(ia.pass), 0);
        // reset during vector 2, after vector 1 has already failed
        mode_a = 1; nd0 = nd_a;
        sweep(7);
        chk("midsweep vec", int'(ia.vec_idx), 2);
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        chk("midreset xy", int'({ia.x, ia.y}), 0);
        chk("midreset busy", int'(ia.busy), 0);
        chk("midreset mask", int'(ia.err_mask), 0);
        repeat (20) @(negedge clk);
        chk("midreset no done", nd_a - nd0, 0);
        mode_a = 0;
        sweep(20);
        chk("post reset pass", int'(ia.pass), 1);
        chk("post reset latency", lat_a, 13);
        // start re-pulsed during vector 1 DRIVE
        nd0 = nd_a;
        sweep(3);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (16) @(negedge clk);
        chk("repulse done count", nd_a - nd0, 1);
        chk("repulse latency", lat_a, 13);
        // start held high: back-to-back sweeps one IDLE cycle apart
        mode_a = 3; tab_a = 4'b1011; nd0 = nd_a;
        @(negedge clk) start = 1'b1;
        repeat (16) @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        chk("held done count", nd_a - nd0, 2);
        chk("held gap", gap_a, 2);
        chk("held mask", int'(ia.err_mask), 4'b1101);
        for (int i = 0; i < 30; i++) begin
            mode_a = int'($urandom_range(0, 3)); mode_b = int'($urandom_range(0, 3));
            tab_a = 4'($urandom); tab_b = 4'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                @(negedge clk) rst_n = 1'b0;
                @(negedge clk) rst_n = 1'b1;
            end
            @(negedge clk) start = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            start = 1'b0;
            repeat ($urandom_range(0, 18)) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
- Sequencer that exhaustively exercises a 2-input combinational gate, e.g. the team's my_xor built from my_and/my_or/my_not.
- Drives x,y through all four combinations, waits a settle interval, samples z and compares it against a parameterised truth table.
- Reports a per-vector error mask and an overall pass flag.
- Sits beside the gate under test as the on-chip replacement for the hand-written stimulus benches.

Parameters:
- SETTLE, 2, cycles x/y are held before z is sampled; legal range 1..15.
- EXPECT, 4'b0110, expected z per vector; bit i is the expected z for {x,y}=i. Default is XOR.

Ports:
- clk  input  1  sole clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  request a sweep; sampled only in IDLE.
- z  input  1  output of the gate under test.
- x  output  1  gate input x (registered).
- y  output  1  gate input y (registered).
- busy  output  1  high from the cycle after start is accepted until FIN is left.
- done  output  1  one-cycle pulse at sweep end.
- pass  output  1  1 if every vector matched; held until the next accepted start.
- err_mask  output  4  bit i set if vector i mismatched; held until the next accepted start.
- vec_idx  output  2  current vector index; equals {x,y} while busy.

Behaviour:
- Reset: one clock; reset is synchronous and active-low. On rst_n=0 at an edge: state=IDLE, x=0, y=0, vec_idx=0, busy=0, done=0, pass=0, err_mask=0, settle counter=0. Reset has priority over all other inputs.
- States: IDLE, DRIVE, CHECK, FIN.
- IDLE:
  - start=1 at an edge -> DRIVE, vec_idx=0, x=0, y=0, err_mask=0, pass=0, settle counter=SETTLE-1, busy=1.
  - start=0 -> stay in IDLE; outputs hold.
- DRIVE:
  - x=vec_idx[1], y=vec_idx[0]. The counter decrements each edge.
  - At the edge where the counter is 0 -> CHECK. DRIVE therefore lasts exactly SETTLE cycles.
- CHECK (one cycle):
  - At the closing edge, z is compared to EXPECT[vec_idx]. On mismatch, set err_mask[vec_idx]. In simulation, z of X or Z counts as a mismatch (case inequality).
  - If vec_idx==3 -> FIN.
  - Otherwise vec_idx increments, x/y update to the new index, the counter reloads to SETTLE-1, and the state goes to DRIVE.
- FIN (one cycle):
  - done=1, pass=(err_mask==0), x=0, y=0.
  - Next edge -> IDLE, busy=0, done=0.
- Latency: each vector takes SETTLE+1 cycles. done is high in the cycle 4*(SETTLE+1)+1 edges after start is sampled; this is 13 at default.
- start while busy (DRIVE/CHECK/FIN) is ignored; no queuing.
- start held high continuously: a new sweep is accepted on the first IDLE edge after FIN (back-to-back sweeps, one IDLE cycle between them).
- x/y change only at DRIVE entry and FIN entry, never during CHECK, so z is stable for at least SETTLE cycles before sampling.
- Reset mid-sweep: sweep abandoned, no done pulse, err_mask/pass cleared to 0. The next start runs a complete sweep from vector 0.
- vec_idx does not wrap during a sweep; 3 is terminal and leads to FIN.

Test Plan:
- Default params, z driven by my_xor(x,y), start pulse -> x,y sequence 00,01,10,11 each held 3 cycles; done 13 edges after start; pass=1, err_mask=4'b0000.
- Default params, z tied 0 -> pass=0, err_mask=4'b0110.
- Default params, z from an AND of x,y -> pass=0, err_mask=4'b1110.
- SETTLE=1, EXPECT=4'b1000, z from an AND of x,y -> done 9 edges after start, pass=1, err_mask=0.
- rst_n=0 for one edge during vector 2 -> x=y=0, busy=0, no done, err_mask=0. A following start completes normally with pass=1 (xor z).
- start re-pulsed during DRIVE of vector 1 -> ignored; single done at cycle 13. start held high -> second sweep begins one cycle after FIN, with err_mask cleared on acceptance.
